button_chord_conditioner: RTL and testbench

//  Conditions the four raw Pynq-Z2 push buttons and feeds the clock divider's btn[3:0] input.

---
 rtl/button_chord_conditioner_if.sv | 12 +
 rtl/button_chord_conditioner.sv | 133 +++++++++++++
 tb/tb_button_chord_conditioner.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_chord_conditioner_if.sv
// Button-side bundle of the chord conditioner: raw buttons in, levels and chord pulse out.
// Purely combinational wiring with no handshake, because the conditioner always accepts button input.
interface button_chord_conditioner_if;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_out;
  logic       btn_valid;
  logic       busy;

  modport master (output btn_raw, input btn_level, btn_out, btn_valid, busy);
  modport slave  (input btn_raw, output btn_level, btn_out, btn_valid, busy);
endinterface

// File: rtl/button_chord_conditioner.sv
// Syncs/debounces 4 buttons (DEBOUNCE_CYCLES+2 latency), ORs presses within CHORD_CYCLES into one registered
// single-cycle chord pulse, never stalls; define HOLD_REPEAT_EN to re-emit the chord every REPEAT_CYCLES while held.
module button_chord_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CHORD_CYCLES    = 8,
  parameter int REPEAT_CYCLES   = 64,
  parameter int CNT_W           = 20
) (
  input logic                        clk_in,
  input logic                        rst_n,
  button_chord_conditioner_if.slave  btn_if
);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, WAIT_RELEASE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(CHORD_CYCLES - 1);

  if ((longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W)) ||
      (longint'(CHORD_CYCLES)    > (longint'(1) << CNT_W)) ||
      (longint'(REPEAT_CYCLES)   > (longint'(1) << CNT_W))) begin : g_cnt_w_too_small
    $error("CNT_W too narrow for the configured cycle counts");
  end

  logic [3:0]            sync1_q, sync2_q;
  logic [3:0]            level_q, level_d;
  logic [3:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      win_q, win_d;
  logic [3:0]            code_q, code_d;
  logic [3:0]            out_q, out_d;
  logic                  vld_q, vld_d;
`ifdef HOLD_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0]      rpt_q, rpt_d;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      deb_cnt_q <= '0;
      state_q   <= IDLE;
      win_q     <= '0;
      code_q    <= '0;
      out_q     <= '0;
      vld_q     <= 1'b0;
`ifdef HOLD_REPEAT_EN
      rpt_q     <= '0;
`endif
    end else begin
      sync1_q   <= btn_if.btn_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      deb_cnt_q <= deb_cnt_d;
      state_q   <= state_d;
      win_q     <= win_d;
      code_q    <= code_d;
      out_q     <= out_d;
      vld_q     <= vld_d;
`ifdef HOLD_REPEAT_EN
      rpt_q     <= rpt_d;
`endif
    end
  end

  // A bit only flips after DEBOUNCE_CYCLES unbroken cycles of disagreement with its current level.
  always_comb begin
    level_d   = level_q;
    deb_cnt_d = deb_cnt_q;
    for (int b = 0; b < 4; b++) begin
      if (sync2_q[b] == level_q[b]) begin
        deb_cnt_d[b] = '0;
      end else if (deb_cnt_q[b] == DEB_LAST) begin
        level_d[b]   = sync2_q[b];
        deb_cnt_d[b] = '0;
      end else begin
        deb_cnt_d[b] = deb_cnt_q[b] + CNT_ONE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (level_q != 4'b0000) state_d = COLLECT;
      COLLECT:      if (win_q == WIN_LAST)  state_d = EMIT;
      EMIT:         state_d = WAIT_RELEASE;
      WAIT_RELEASE: if (level_q == 4'b0000) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // The pulse is loaded on the COLLECT->EMIT edge so it is visible during the EMIT cycle itself.
  always_comb begin
    code_d = code_q;
    win_d  = win_q;
    out_d  = '0;
`ifdef HOLD_REPEAT_EN
    rpt_d  = '0;
`endif
    case (state_q)
      IDLE: begin
        code_d = level_q;
        win_d  = '0;
      end
      COLLECT: begin
        code_d = code_q | level_q;
        win_d  = win_q + CNT_ONE;
        if (win_q == WIN_LAST) out_d = code_q | level_q;
      end
`ifdef HOLD_REPEAT_EN
      EMIT: rpt_d = rpt_q + CNT_ONE;
      WAIT_RELEASE: begin
        if (level_q != 4'b0000) begin
          if (rpt_q == RPT_LAST) out_d = code_q;
          else                   rpt_d = rpt_q + CNT_ONE;
        end
      end
`endif
      default: ;
    endcase
    vld_d = |out_d;
  end

  assign btn_if.btn_level = level_q;
  assign btn_if.btn_out   = out_q;
  assign btn_if.btn_valid = vld_q;
  assign btn_if.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_button_chord_conditioner.sv
// Bench for button_chord_conditioner: per-cycle comparison against an array-based model of the chord rules.
// Cycle index k in every trace is the (k+1)-th rising edge after reset release.
module tb_button_chord_conditioner;

  localparam int D    = 4;
  localparam int C    = 8;
  localparam int R    = 16;
  localparam int MAXN = 600;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [3:0] stim    [MAXN];
  logic [3:0] obs_lvl [MAXN];
  logic [3:0] obs_out [MAXN];
  logic       obs_vld [MAXN];
  logic       obs_busy[MAXN];
  logic [3:0] exp_lvl [MAXN];
  logic [3:0] exp_out [MAXN];
  logic       exp_busy[MAXN];

  button_chord_conditioner_if bif ();

  button_chord_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CHORD_CYCLES   (C),
    .REPEAT_CYCLES  (R),
    .CNT_W          (20)
  ) dut (
    .clk_in (clk),
    .rst_n  (rst_n),
    .btn_if (bif)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // stim[k] is the raw value present before edge k; stim[0] is also held during reset.
  task automatic apply_and_record(input int n);
    rst_n = 1'b0;
    bif.btn_raw = stim[0];
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      obs_lvl[k]  = bif.btn_level;
      obs_out[k]  = bif.btn_out;
      obs_vld[k]  = bif.btn_valid;
      obs_busy[k] = bif.busy;
      bif.btn_raw = (k + 1 < n) ? stim[k + 1] : stim[n - 1];
    end
  endtask

  // Level: a bit flips once the previous D synced samples all disagree with it. Chords: OR of the
  // level over C+1 cycles from the first press, emitted C+1 cycles later, busy until full release.
  task automatic build_model(input int n);
    logic [3:0] sy [MAXN];
    logic [3:0] lv;
    logic [3:0] code;
    logic       flip, s;
    int         idx, idle, r, e, z;
    for (int m = 0; m < n; m++) sy[m] = (m >= 1) ? stim[m - 1] : 4'b0000;
    lv = 4'b0000;
    for (int m = 0; m < n; m++) begin
      for (int b = 0; b < 4; b++) begin
        flip = 1'b1;
        for (int i = 1; i <= D; i++) begin
          idx = m - i;
          s = (idx >= 0) ? sy[idx][b] : 1'b0;
          if (s == lv[b]) flip = 1'b0;
        end
        if (flip) lv[b] = ~lv[b];
      end
      exp_lvl[m]  = lv;
      exp_out[m]  = 4'b0000;
      exp_busy[m] = 1'b0;
    end
    idle = 0;
    while (idle < n) begin
      r = -1;
      for (int m = idle; m < n; m++) if (exp_lvl[m] != 4'b0000) begin r = m; break; end
      if (r < 0) break;
      e = r + C + 1;
      code = 4'b0000;
      for (int m = r; m <= r + C && m < n; m++) code |= exp_lvl[m];
      if (e < n) exp_out[e] = code;
      z = n;
      for (int m = e + 1; m < n; m++) if (exp_lvl[m] == 4'b0000) begin z = m; break; end
      for (int m = r + 1; m <= z && m < n; m++) exp_busy[m] = 1'b1;
`ifdef HOLD_REPEAT_EN
      for (int j = 1; (e + R * j < n) && (e + R * j <= z); j++) exp_out[e + R * j] = code;
`endif
      idle = z + 1;
    end
  endtask

  function automatic int count_pulses(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (obs_vld[k] === 1'b1) c++;
    return c;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bif.btn_raw = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bif.btn_level, bif.btn_out, bif.btn_valid, bif.busy} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_state: lvl/out/vld/busy got %b/%b/%b/%b want 0000/0000/0/0",
               bif.btn_level, bif.btn_out, bif.btn_valid, bif.busy);
    end
  endtask

  task automatic test_held_through_reset();
    int n = 40;
    int first = -1;
    for (int k = 0; k < n; k++) stim[k] = 4'b1111;
    apply_and_record(n);
    build_model(n);
    for (int k = 0; k < n; k++) begin
      n_checks++;
      if ({obs_lvl[k], obs_out[k], obs_vld[k], obs_busy[k]} !== {exp_lvl[k], exp_out[k], exp_out[k] != 4'b0, exp_busy[k]}) begin
        n_fail++;
        $display("FAIL held_reset cyc %0d: lvl/out/vld/busy got %b/%b/%b/%b want %b/%b/%b/%b", k,
                 obs_lvl[k], obs_out[k], obs_vld[k], obs_busy[k], exp_lvl[k], exp_out[k], exp_out[k] != 4'b0, exp_busy[k]);
      end
    end
    for (int k = 0; k < n; k++) if (first < 0 && obs_lvl[k] === 4'b1111) first = k;
    n_checks++;
    if (first != 5) begin n_fail++; $display("FAIL held_reset level_edge: got cycle %0d want 5", first); end
    n_checks++;
    if (obs_out[14] !== 4'b1111) begin n_fail++; $display("FAIL held_reset pulse: got %b want 1111", obs_out[14]); end
    n_checks++;
    if (count_pulses(n) != 1) begin n_fail++; $display("FAIL held_reset pulse_count: got %0d want 1", count_pulses(n)); end
  endtask

  task automatic test_bounce();
    int n = 60;
    for (int k = 0; k < n; k++) stim[k] = (k < 20) ? {3'b000, 1'((k / 2) % 2)} : 4'b0001;
    apply_and_record(n);
    build_model(n);
    for (int k = 0; k < n; k++) begin
      n_checks++;
      if ({obs_lvl[k], obs_out[k], obs_vld[k], obs_busy[k]} !== {exp_lvl[k], exp_out[k], exp_out[k] != 4'b0, exp_busy[k]}) begin
        n_fail++;
        $display("FAIL bounce cyc %0d: lvl/out/vld/busy got %b/%b/%b/%b want %b/%b/%b/%b", k,
                 obs_lvl[k], obs_out[k], obs_vld[k], obs_busy[k], exp_lvl[k], exp_out[k], exp_out[k] != 4'b0, exp_busy[k]);
      end
    end
    n_checks++;
    if (count_pulses(n) != 1) begin n_fail++; $display("FAIL bounce pulse_count: got %0d want 1", count_pulses(n)); end
  endtask

  task automatic test_stagger();
    int n = 60;
    int f3 = -1;
    int f0 = -1;
    for (int k = 0; k < n; k++) stim[k] = (k < 3) ? 4'b1000 : (k < 40) ? 4'b1001 : 4'b0000;
    apply_and_record(n);
    build_model(n);
    for (int k = 0; k < n; k++) begin
      n_checks++;
      if ({obs_lvl[k], obs_out[k], obs_vld[k], obs_busy[k]} !== {exp_lvl[k], exp_out[k], exp_out[k] != 4'b0, exp_busy[k]}) begin
        n_fail++;
        $display("FAIL stagger cyc %0d: lvl/out/vld/busy got %b/%b/%b/%b want %b/%b/%b/%b", k,
                 obs_lvl[k], obs_out[k], obs_vld[k], obs_busy[k], exp_lvl[k], exp_out[k], exp_out[k] != 4'b0, exp_busy[k]);
      end
    end
    for (int k = 0; k < n; k++) begin
      if (f3 < 0 && obs_lvl[k][3] === 1'b1) f3 = k;
      if (f0 < 0 && obs_lvl[k][0] === 1'b1) f0 = k;
    end
    n_checks++;
    if (f3 != 5 || f0 != 8) begin n_fail++; $display("FAIL stagger level_edges: got %0d/%0d want 5/8", f3, f0); end
    n_checks++;
    if (obs_out[14] !== 4'b1001 || obs_vld[14] !== 1'b1) begin
      n_fail++; $display("FAIL stagger pulse: got %b vld %b want 1001 vld 1", obs_out[14], obs_vld[14]);
    end
    n_checks++;
    if (count_pulses(n) != 1) begin n_fail++; $display("FAIL stagger pulse_count: got %0d want 1", count_pulses(n)); end
  endtask

  task automatic test_hold_then_new();
    int n = 100;
    int p = 0;
    logic [3:0] codes [2];
    for (int k = 0; k < n; k++)
      stim[k] = (k < 30) ? 4'b0011 : (k < 45) ? 4'b0111 : (k < 60) ? 4'b0000 : (k < 75) ? 4'b0100 : 4'b0000;
    apply_and_record(n);
    build_model(n);
    for (int k = 0; k < n; k++) begin
      n_checks++;
      if ({obs_lvl[k], obs_out[k], obs_vld[k], obs_busy[k]} !== {exp_lvl[k], exp_out[k], exp_out[k] != 4'b0, exp_busy[k]}) begin
        n_fail++;
        $display("FAIL hold_new cyc %0d: lvl/out/vld/busy got %b/%b/%b/%b want %b/%b/%b/%b", k,
                 obs_lvl[k], obs_out[k], obs_vld[k], obs_busy[k], exp_lvl[k], exp_out[k], exp_out[k] != 4'b0, exp_busy[k]);
      end
    end
`ifndef HOLD_REPEAT_EN
    codes[0] = 4'b0000;
    codes[1] = 4'b0000;
    for (int k = 0; k < n; k++) if (obs_vld[k] === 1'b1) begin if (p < 2) codes[p] = obs_out[k]; p++; end
    n_checks++;
    if (p != 2 || codes[0] !== 4'b0011 || codes[1] !== 4'b0100) begin
      n_fail++; $display("FAIL hold_new pulses: got %0d pulses %b,%b want 2 pulses 0011,0100", p, codes[0], codes[1]);
    end
`endif
  endtask

  task automatic test_random();
    int n = 500;
    int k = 0;
    int len;
    logic [3:0] v;
    while (k < n) begin
      v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) v = 4'b0000;
      len = $urandom_range(1, 30);
      for (int i = 0; i < len && k < n; i++) begin stim[k] = v; k++; end
    end
    for (int i = n - 30; i < n; i++) stim[i] = 4'b0000;
    apply_and_record(n);
    build_model(n);
    for (int j = 0; j < n; j++) begin
      n_checks++;
      if ({obs_lvl[j], obs_out[j], obs_vld[j], obs_busy[j]} !== {exp_lvl[j], exp_out[j], exp_out[j] != 4'b0, exp_busy[j]}) begin
        n_fail++;
        $display("FAIL random cyc %0d: lvl/out/vld/busy got %b/%b/%b/%b want %b/%b/%b/%b", j,
                 obs_lvl[j], obs_out[j], obs_vld[j], obs_busy[j], exp_lvl[j], exp_out[j], exp_out[j] != 4'b0, exp_busy[j]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int budget = 0;
    int pulses = 0;
    rst_n = 1'b0;
    bif.btn_raw = 4'b0101;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    while (bif.busy !== 1'b1 && budget < 40) begin @(posedge clk); #1; budget++; end
    n_checks++;
    if (bif.busy !== 1'b1) begin n_fail++; $display("FAIL mid_reset busy_rise: got %b want 1", bif.busy); end
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    bif.btn_raw = 4'b0000;
    #1;
    n_checks++;
    if ({bif.btn_level, bif.btn_out, bif.btn_valid, bif.busy} !== 10'b0) begin
      n_fail++;
      $display("FAIL mid_reset immediate: lvl/out/vld/busy got %b/%b/%b/%b want 0000/0000/0/0",
               bif.btn_level, bif.btn_out, bif.btn_valid, bif.busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bif.btn_valid !== 1'b0 || bif.busy !== 1'b0) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL mid_reset after: got %0d active cycles want 0", pulses); end
  endtask

`ifdef HOLD_REPEAT_EN
  task automatic test_repeat();
    int n = 110;
    int p = 0;
    int at [4];
    for (int k = 0; k < n; k++) stim[k] = (k < 70) ? 4'b0010 : 4'b0000;
    apply_and_record(n);
    build_model(n);
    for (int k = 0; k < n; k++) begin
      n_checks++;
      if ({obs_lvl[k], obs_out[k], obs_vld[k], obs_busy[k]} !== {exp_lvl[k], exp_out[k], exp_out[k] != 4'b0, exp_busy[k]}) begin
        n_fail++;
        $display("FAIL repeat cyc %0d: lvl/out/vld/busy got %b/%b/%b/%b want %b/%b/%b/%b", k,
                 obs_lvl[k], obs_out[k], obs_vld[k], obs_busy[k], exp_lvl[k], exp_out[k], exp_out[k] != 4'b0, exp_busy[k]);
      end
    end
    for (int i = 0; i < 4; i++) at[i] = -1;
    for (int k = 0; k < n; k++) if (obs_vld[k] === 1'b1) begin if (p < 4) at[p] = k; p++; end
    n_checks++;
    if (p != 4 || at[0] != 14 || at[1] != 30 || at[2] != 46 || at[3] != 62) begin
      n_fail++;
      $display("FAIL repeat schedule: got %0d pulses at %0d,%0d,%0d,%0d want 4 at 14,30,46,62",
               p, at[0], at[1], at[2], at[3]);
    end
  endtask
`endif

  initial begin
    bif.btn_raw = 4'b0000;
    test_reset();
    test_held_through_reset();
    test_bounce();
    test_stagger();
    test_hold_then_new();
    test_random();
    test_mid_reset();
`ifdef HOLD_REPEAT_EN
    test_repeat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
